// File: rtl/rc4_xor_stage_if.sv
// rc4_xor_stage_if: keystream, data-in and result byte valid/ready channels
interface rc4_xor_stage_if;
  logic       ks_valid, ks_ready, din_valid, din_ready, dout_valid, dout_ready;
  logic [7:0] ks_data, din_data, dout_data;
  modport slave (
    input  ks_valid, ks_data, din_valid, din_data, dout_ready,
    output ks_ready, din_ready, dout_valid, dout_data
  );
  modport master (
    output ks_valid, ks_data, din_valid, din_data, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/rc4_xor_stage.sv
// rc4_xor_stage: keystream FIFO + XOR of data bytes; RC4_DROP_N_EN discards the first DROP_N keystream bytes
module rc4_xor_stage #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DROP_N = 256
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  rc4_xor_stage_if.slave         bus,
  output logic [CNT_W-1:0]       byte_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          clr, run, full, empty, push, pop;
`ifdef RC4_DROP_N_EN
  localparam int unsigned DW = $clog2(DROP_N + 1);
  typedef enum logic {DROP, RUN} state_t;
  state_t        state;
  logic [DW-1:0] drop_cnt;
  always_ff @(posedge wb_clk_i)
    if (clr) begin
      state    <= DROP;
      drop_cnt <= '0;
    end else if (state == DROP && bus.ks_valid) begin
      state    <= (drop_cnt == DW'(DROP_N - 1)) ? RUN : DROP;
      drop_cnt <= drop_cnt + DW'(1);
    end
  assign run = state == RUN;
`else
  assign run = 1'b1;
`endif
  always_comb begin
    clr           = wb_rst_i || start;
    full          = fifo_level == LW'(DEPTH);
    empty         = fifo_level == '0;
    bus.ks_ready  = !start && (!run || !full);
    bus.din_ready = !start && run && !empty && (!bus.dout_valid || bus.dout_ready);
    push          = bus.ks_valid && bus.ks_ready && run;
    pop           = bus.din_valid && bus.din_ready;
  end
  always_ff @(posedge wb_clk_i)
    if (push) mem[wr_ptr] <= bus.ks_data;
  always_ff @(posedge wb_clk_i)
    if (clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_data  <= '0;
      byte_count     <= '0;
    end else begin
      wr_ptr         <= wr_ptr + AW'(push);
      rd_ptr         <= rd_ptr + AW'(pop);
      fifo_level     <= fifo_level + LW'(push) - LW'(pop);
      bus.dout_valid <= pop || (bus.dout_valid && !bus.dout_ready);
      if (pop) bus.dout_data <= bus.din_data ^ mem[rd_ptr];
      if (bus.dout_valid && bus.dout_ready && !(&byte_count)) byte_count <= byte_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_rc4_xor_stage.sv
// tb_rc4_xor_stage: directed table-driven checks of the keystream XOR stage
module tb_rc4_xor_stage;
`ifdef RC4_DROP_N_EN
  localparam int DROP_N = 4;
`else
  localparam int DROP_N = 256;
`endif
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] byte_count;
  logic [3:0]  fifo_level;
  int          checks = 0, errors = 0;
  rc4_xor_stage_if bus();
  rc4_xor_stage #(.DEPTH(8), .CNT_W(16), .DROP_N(DROP_N)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .bus(bus),
    .byte_count(byte_count), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, kv; logic [7:0] kd; logic iv; logic [7:0] id; logic dr;
    logic ksr, dinr, dv; logic [7:0] dd; logic [15:0] bc; logic [3:0] lvl;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic st, kv, input logic [7:0] kd, input logic iv,
                              input logic [7:0] id, input logic dr, ksr, dinr, dv,
                              input logic [7:0] dd, input logic [15:0] bc, input logic [3:0] lvl);
    mk = '{st, kv, kd, iv, id, dr, ksr, dinr, dv, dd, bc, lvl};
  endfunction
  task automatic cmp(input string n, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk(input string n, input logic ksr, dinr, dv, input logic [7:0] dd,
                     input logic [15:0] bc, input logic [3:0] lvl);
    cmp({n, ".ks_ready"}, 16'(bus.ks_ready), 16'(ksr));
    cmp({n, ".din_ready"}, 16'(bus.din_ready), 16'(dinr));
    cmp({n, ".dout_valid"}, 16'(bus.dout_valid), 16'(dv));
    cmp({n, ".dout_data"}, 16'(bus.dout_data), 16'(dd));
    cmp({n, ".byte_count"}, byte_count, bc);
    cmp({n, ".fifo_level"}, 16'(fifo_level), 16'(lvl));
  endtask
  task automatic drive(input logic st, kv, input logic [7:0] kd, input logic iv,
                       input logic [7:0] id, input logic dr);
    @(negedge clk);
    start         = st;
    bus.ks_valid  = kv;
    bus.ks_data   = kd;
    bus.din_valid = iv;
    bus.din_data  = id;
    bus.dout_ready = dr;
  endtask
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].kv, tbl[i].kd, tbl[i].iv, tbl[i].id, tbl[i].dr);
      #2 chk($sformatf("%s[%0d]", tag, i), tbl[i].ksr, tbl[i].dinr, tbl[i].dv,
             tbl[i].dd, tbl[i].bc, tbl[i].lvl);
    end
    tbl.delete();
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.ks_valid = 1'b0; bus.ks_data = '0;
    bus.din_valid = 1'b0; bus.din_data = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2 chk("reset", 1, 0, 0, 8'h00, 0, 0);
`ifdef RC4_DROP_N_EN
    for (int c = 0; c < 4; c++) tbl.push_back(mk(0, 1, 8'(c), 1, 0, 1, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h05, 1, 0, 1, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h04, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'h05, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h05, 2, 0));
    run_tbl("drop");
`else
    tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h3C, 1, 8'hFF, 1, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h00, 1, 1, 1, 1, 8'h5A, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'h3C, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h3C, 2, 0));
    run_tbl("basic");
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 8'(8'h10 + i), 0, 0, 0);
      #2 chk($sformatf("fill%0d", i), i < 8, i > 0, 0, 8'h3C, 2, 4'(i));
    end
    for (int j = 0; j < 11; j++) begin
      drive(0, j <= 1, 8'h18, j <= 8, 8'h00, 1);
      #2 chk($sformatf("drain%0d", j), j != 0, j <= 8, j >= 1 && j <= 9,
             j == 0 ? 8'h3C : (j <= 9 ? 8'(8'h10 + j - 1) : 8'h18),
             j <= 1 ? 16'd2 : 16'(1 + j),
             j == 0 ? 4'd8 : (j == 1 ? 4'd7 : (j <= 9 ? 4'(9 - j) : 4'd0)));
    end
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h11, 0, 1, 0, 0, 8'h18, 11, 0));
    tbl.push_back(mk(0, 1, 8'h22, 1, 8'h11, 0, 1, 0, 0, 8'h18, 11, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h11, 0, 1, 1, 0, 8'h18, 11, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 8'h33, 11, 0));
    tbl.push_back(mk(0, 1, 8'h44, 0, 8'h00, 0, 1, 0, 1, 8'h33, 11, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h55, 0, 1, 0, 1, 8'h33, 11, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h55, 1, 1, 1, 1, 8'h33, 11, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 8'h11, 12, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, 8'(8'h60 + k), 0, 0, 0, 1, 0, 1, 8'h11, 12, 4'(k)));
    tbl.push_back(mk(1, 1, 8'h77, 1, 8'h99, 1, 0, 0, 1, 8'h11, 12, 5));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));
    run_tbl("hold_start");
    for (int k = 0; k < 65545; k++) drive(0, 1, k[7:0], 1, 8'h00, 1);
    repeat (3) drive(0, 0, 8'h00, 0, 8'h00, 1);
    #2 cmp("saturate.byte_count", byte_count, 16'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
